// File: rtl/varredura_servo_pkg.sv
// Shared definitions for the servo position sequencer.
//   State codes (also exported on estado_db) and the 2-bit position codes
//   driven onto the PWM width-select input, plus the single-step helper.
package varredura_servo_pkg;

    localparam int unsigned EST_W = 2;
    localparam int unsigned POS_W = 2;

    localparam logic [1:0] PARADO = 2'd0;
    localparam logic [1:0] ESPERA = 2'd1;
    localparam logic [1:0] PASSO  = 2'd2;
    localparam logic [1:0] MANUAL = 2'd3;

    localparam logic [1:0] POS_00 = 2'b00;
    localparam logic [1:0] POS_01 = 2'b01;
    localparam logic [1:0] POS_10 = 2'b10;
    localparam logic [1:0] POS_11 = 2'b11;

    // One position step; callers guarantee no step past an endpoint.
    function automatic logic [1:0] passo_pos(input logic [1:0] pos, input logic sobe);
        return sobe ? pos + 2'd1 : pos - 2'd1;
    endfunction

endpackage

// File: rtl/varredura_servo_contador_espera.sv
// Modulo-M dwell counter.
//   clock, reset : clock / async active-high reset
//   limpa_i      : synchronous clear (priority over habilita_i)
//   habilita_i   : count enable; wraps to 0 after M-1
//   fim_c        : terminal count (count == M-1), combinational from the register
module contador_espera #(
    parameter int unsigned M = 4,
    parameter int unsigned W = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa_i,
    input  logic habilita_i,
    output logic fim_c
);

    logic [W-1:0] contagem_q;
    logic [W-1:0] contagem_d;

    assign fim_c = (contagem_q == W'(M - 1));

    always_comb begin
        contagem_d = contagem_q;
        if (limpa_i) begin
            contagem_d = '0;
        end else if (habilita_i) begin
            contagem_d = fim_c ? '0 : contagem_q + W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem_q <= '0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

endmodule

// File: rtl/varredura_servo.sv
// Servo position sequencer: ping-pong sweep 00..11..00 with a programmable
// dwell per position, or manual pass-through of an external code.
//   clock, reset     : clock / async active-high reset
//   ligar            : sweep enable
//   manual           : manual mode (priority over ligar)
//   posicao_manual   : code loaded in manual mode
//   largura          : registered position code to the PWM generator
//   direcao          : direction of the next sweep step (1 = up)
//   mudou            : one-cycle pulse on every actual change of largura
//   estado_db        : current state code
module varredura_servo
    import varredura_servo_pkg::*;
#(
    parameter int unsigned conf_espera      = 50000000,
    parameter int unsigned largura_contador = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ligar,
    input  logic             manual,
    input  logic [POS_W-1:0] posicao_manual,
    output logic [POS_W-1:0] largura,
    output logic             direcao,
    output logic             mudou,
    output logic [EST_W-1:0] estado_db
);

    logic [EST_W-1:0] estado_q,  estado_d;
    logic [POS_W-1:0] largura_q, largura_d;
    logic             direcao_q, direcao_d;
    logic             mudou_q,   mudou_d;

    logic             fim_c;
    logic             limpa_c;
    logic             habilita_c;
    logic             sobe_c;
    logic [POS_W-1:0] prox_pos_c;

    // Dwell counter only runs while staying in ESPERA; any other path re-arms it at 0.
    contador_espera #(
        .M (conf_espera),
        .W (largura_contador)
    ) u_contador (
        .clock      (clock),
        .reset      (reset),
        .limpa_i    (limpa_c),
        .habilita_i (habilita_c),
        .fim_c      (fim_c)
    );

    // Next state, step and change detection.
    always_comb begin
        estado_d   = estado_q;
        largura_d  = largura_q;
        direcao_d  = direcao_q;
        mudou_d    = 1'b0;
        sobe_c     = direcao_q;
        prox_pos_c = largura_q;

        // Endpoints override a stale direction (e.g. after manual mode).
        if (largura_q == POS_00) begin
            sobe_c = 1'b1;
        end else if (largura_q == POS_11) begin
            sobe_c = 1'b0;
        end
        prox_pos_c = passo_pos(largura_q, sobe_c);

        if (manual) begin
            estado_d = MANUAL;
        end else if (!ligar) begin
            estado_d = PARADO;
        end else begin
            case (estado_q)
                ESPERA:  estado_d = fim_c ? PASSO : ESPERA;
                PASSO:   estado_d = ESPERA;
                default: estado_d = ESPERA;
            endcase
        end

        // A step is only committed when PASSO is not overridden.
        if (estado_d == MANUAL) begin
            largura_d = posicao_manual;
        end else if ((estado_q == PASSO) && (estado_d == ESPERA)) begin
            largura_d = prox_pos_c;
            if (prox_pos_c == POS_11) begin
                direcao_d = 1'b0;
            end else if (prox_pos_c == POS_00) begin
                direcao_d = 1'b1;
            end else begin
                direcao_d = sobe_c;
            end
        end

        mudou_d = (largura_d != largura_q);
    end

    assign limpa_c    = (estado_q != ESPERA) || (estado_d != ESPERA);
    assign habilita_c = (estado_q == ESPERA);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= PARADO;
            largura_q <= POS_00;
            direcao_q <= 1'b1;
            mudou_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            largura_q <= largura_d;
            direcao_q <= direcao_d;
            mudou_q   <= mudou_d;
        end
    end

    assign largura   = largura_q;
    assign direcao   = direcao_q;
    assign mudou     = mudou_q;
    assign estado_db = estado_q;

endmodule

// File: tb/tb_varredura_servo.sv
// Bench for varredura_servo with conf_espera=4 (step period 5 clocks).
module tb_varredura_servo;

    localparam int CONF = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       manual;
    logic [1:0] posicao_manual;
    logic [1:0] largura;
    logic       direcao;
    logic       mudou;
    logic [1:0] estado_db;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    varredura_servo #(
        .conf_espera      (CONF),
        .largura_contador (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ligar          (ligar),
        .manual         (manual),
        .posicao_manual (posicao_manual),
        .largura        (largura),
        .direcao        (direcao),
        .mudou          (mudou),
        .estado_db      (estado_db)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode (0 idle,1 dwelling,2 step due,3 manual),
    // position as an integer 0..3, dwell cycles elapsed.
    int m_mode, m_pos, m_dir, m_wait, m_mudou, m_new;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_pos = 0; m_dir = 1; m_wait = 0; m_mudou = 0;
        end else begin
            m_new = m_pos;
            if (manual) begin
                m_mode = 3;
                m_wait = 0;
                m_new  = int'(posicao_manual);
            end else if (!ligar) begin
                m_mode = 0;
                m_wait = 0;
            end else if (m_mode == 1) begin
                if (m_wait == CONF - 1) begin
                    m_mode = 2;
                    m_wait = 0;
                end else begin
                    m_wait = m_wait + 1;
                end
            end else if (m_mode == 2) begin
                // Move towards the far end; at an endpoint the only way is back.
                if (m_pos == 0) m_dir = 1;
                if (m_pos == 3) m_dir = 0;
                m_new = m_dir ? m_pos + 1 : m_pos - 1;
                if (m_new == 3) m_dir = 0;
                if (m_new == 0) m_dir = 1;
                m_mode = 1;
            end else begin
                m_mode = 1;
                m_wait = 0;
            end
            m_mudou = (m_new != m_pos) ? 1 : 0;
            m_pos   = m_new;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_largura", int'(largura),   m_pos);
            chk("model_direcao", int'(direcao),   m_dir);
            chk("model_mudou",   int'(mudou),     m_mudou);
            chk("model_estado",  int'(estado_db), m_mode);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    int seq [7] = '{1, 2, 3, 2, 1, 0, 1};
    int idx;

    initial begin
        reset = 1'b1; ligar = 1'b0; manual = 1'b0; posicao_manual = 2'd0;
        tick(2);
        reset = 1'b0;
        chk_en = 1'b1;

        // 1: idle after reset
        for (int k = 0; k < 20; k++) begin
            tick(1);
            chk("idle_largura", int'(largura), 0);
            chk("idle_direcao", int'(direcao), 1);
            chk("idle_mudou",   int'(mudou),   0);
            chk("idle_estado",  int'(estado_db), 0);
        end

        // 2: full sweep, change every 5 clocks starting 6 negedges after ligar
        ligar = 1'b1;
        idx = 0;
        for (int k = 1; k <= 36; k++) begin
            tick(1);
            chk("sweep_mudou", int'(mudou), (k >= 6 && (k % 5) == 1) ? 1 : 0);
            if (mudou && idx < 7) begin
                chk("sweep_largura", int'(largura), seq[idx]);
                if (idx == 2) chk("sweep_dir_at_11", int'(direcao), 0);
                if (idx == 5) chk("sweep_dir_at_00", int'(direcao), 1);
                idx++;
            end
        end
        chk("sweep_count", idx, 7);

        // 3: drop ligar after 2 dwell cycles, resume 10 cycles later
        tick(1);
        ligar = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("pause_largura", int'(largura), 1);
            chk("pause_estado",  int'(estado_db), 0);
            chk("pause_mudou",   int'(mudou), 0);
        end
        ligar = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk("resume_mudou", int'(mudou), (k == 6) ? 1 : 0);
        end
        chk("resume_largura", int'(largura), 2);
        tick(5);
        chk("resume_largura2", int'(largura), 3);

        // 4: manual overrides the sweep
        manual = 1'b1; posicao_manual = 2'b10;
        tick(1);
        chk("man_largura", int'(largura), 2);
        chk("man_mudou",   int'(mudou), 1);
        chk("man_estado",  int'(estado_db), 3);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("man_same_mudou", int'(mudou), 0);
        end
        posicao_manual = 2'b01;
        tick(1);
        chk("man_01_largura", int'(largura), 1);
        chk("man_01_mudou",   int'(mudou), 1);
        tick(1);
        chk("man_01_mudou_off", int'(mudou), 0);

        // 5: sweep down to 00 so direcao=1, then park at 11 manually and release
        manual = 1'b0;
        tick(6);
        chk("pre5_largura", int'(largura), 0);
        chk("pre5_direcao", int'(direcao), 1);
        manual = 1'b1; posicao_manual = 2'b11;
        tick(2);
        chk("m11_largura", int'(largura), 3);
        chk("m11_direcao", int'(direcao), 1);
        manual = 1'b0;
        tick(5);
        chk("rel_hold", int'(largura), 3);
        tick(1);
        chk("rel_largura", int'(largura), 2);
        chk("rel_direcao", int'(direcao), 0);
        chk("rel_mudou",   int'(mudou), 1);

        // 6: async reset during PASSO
        tick(4);
        chk("passo_estado", int'(estado_db), 2);
        #2 reset = 1'b1;
        #1;
        chk("rst_largura", int'(largura), 0);
        chk("rst_direcao", int'(direcao), 1);
        chk("rst_mudou",   int'(mudou), 0);
        chk("rst_estado",  int'(estado_db), 0);
        ligar = 1'b0;
        tick(2);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("post_rst_largura", int'(largura), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/varredura_servo.md
Name: varredura_servo

Overview:
Position sequencer that sits directly upstream of the servo PWM generator and drives its 2-bit width-select input `largura`. In sweep mode it steps the code ping-pong through 00→01→10→11→10→01→00… and holds each position for a programmable dwell time. In manual mode it passes an external position straight through. A one-cycle `mudou` pulse flags every code change, for downstream logging and display.

Parameters:
conf_espera, 50000000, dwell per position in clocks (1 s at 50 MHz); legal range ≥1.
largura_contador, 32, width of the dwell counter; must hold conf_espera-1.

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
ligar  in  1  1 = sweep enabled
manual  in  1  1 = manual mode; has priority over ligar
posicao_manual  in  2  position code used in manual mode
largura  out  2  registered position code, to the PWM `largura` input
direcao  out  1  direction of the next sweep step (1 = up, 0 = down)
mudou  out  1  one-cycle pulse, high in the first cycle a new `largura` value is visible
estado_db  out  2  debug state code: PARADO=0, ESPERA=1, PASSO=2, MANUAL=3

Behaviour:
- Reset (asynchronous, any time, including mid-PASSO):
  - state=PARADO, largura=00, direcao=1, mudou=0, dwell counter=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Mode priority, evaluated every cycle from any state:
  - manual=1 → MANUAL.
  - otherwise, ligar=0 → PARADO.
- PARADO:
  - largura held, counter held at 0.
  - ligar=1 (and manual=0) → ESPERA with counter=0.
- ESPERA:
  - Counter increments each cycle.
  - At counter==conf_espera-1 → PASSO, counter cleared.
  - Leaving to PARADO or MANUAL clears the counter. On resume, the dwell restarts from 0; partial dwell is not kept.
- PASSO (exactly one cycle):
  - Effective direction: up if largura==00, down if largura==11, else `direcao`.
  - largura_next = largura ±1 per the effective direction. No wrap-around is ever allowed.
  - direcao_next = 0 if largura_next==11; 1 if largura_next==00; else the effective direction.
  - Then → ESPERA, unless manual or ligar overrides.
- Sweep timing:
  - From entry into ESPERA with counter=0, `largura` changes on the edge ending PASSO.
  - Steady-state period between changes is conf_espera+1 clocks.
  - The first change after ligar rises lands conf_espera+1 clocks after the first ESPERA cycle.
- MANUAL:
  - largura <= posicao_manual every cycle (one-cycle latency).
  - `direcao` is held.
  - On manual falling: → ESPERA (counter=0) if ligar=1, else PARADO. The sweep continues from the current code; the endpoint rule above fixes a stale `direcao`.
- mudou:
  - Registered: 1 in exactly the cycle where the new `largura` first appears.
  - Fires only if the value actually differs from the previous one. Rewriting the same manual code gives no pulse.
  - Never high out of reset.
- Simultaneous events:
  - manual rising in the PASSO cycle: MANUAL wins and no step is taken; `largura` takes posicao_manual.
  - ligar falling at counter==conf_espera-1: → PARADO and no step is taken.
- conf_espera=1: ESPERA lasts one cycle; the sweep period is 2 clocks.

Decomposition:
- Shared package/include holds:
  - state encodings PARADO/ESPERA/PASSO/MANUAL, 2 bits, reused by estado_db;
  - position codes POS_00..POS_11.
- Natural sub-module: contador_espera, a parameterised modulo-M counter with clear, enable and terminal-count output, instantiated with M=conf_espera.
- The FSM, step logic and mudou detection stay in the top module.

Test Plan (conf_espera=4, so the step period is 5 clocks):
1. Reset, then idle with ligar=0 and manual=0 → largura=00, direcao=1, mudou=0, estado_db=0, stable for 20 cycles.
2. ligar=1 held → largura goes 01,10,11,10,01,00,01, one change every 5 clocks with a mudou pulse on each. direcao=0 from the edge largura hits 11; back to 1 at 00.
3. ligar dropped after 2 ESPERA cycles, re-raised 10 cycles later → largura held while low, estado_db=0, no mudou. The next change comes a full 5 clocks after resume.
4. manual=1 with posicao_manual=10, ligar=1 → largura=10 one cycle later, mudou pulses once, estado_db=3. Rewriting 10 gives no pulse; changing to 01 gives one pulse.
5. manual sets 11 with direcao=1, then manual falls with ligar=1 → 5 clocks later largura=10, direcao=0, no overflow to 00.
6. Reset asserted asynchronously mid-sweep during the PASSO cycle → outputs return to reset values immediately (largura=00, direcao=1, mudou=0). No step is taken.
